// File: rtl/systolic_ws_feeder_if.sv
// rtl/systolic_ws_feeder_if.sv - controller/SRAM/datapath bundle for the weight-stationary row feeder
//
// Signals:
//   start, row_count      controller -> feeder : batch command and row count
//   busy, done            feeder -> controller : status
//   row_rd_en, row_rdaddr feeder -> source SRAM: per-lane read request
//   row_rddata            source SRAM -> feeder: per-lane read data (1-cycle latency)
//   row_data_out          feeder -> datapath   : skewed lanes for row_data_in
// Modports: slave (the feeder), master (controller + SRAM + datapath side).
interface systolic_ws_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_NUM    = 8,
    parameter int LENGTH     = 8
);
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);
    localparam int CNT_WIDTH      = $clog2(ROW_NUM + LENGTH);

    logic                      start;
    logic [CNT_WIDTH-1:0]      row_count;
    logic                      busy;
    logic                      done;
    logic                      row_rd_en    [0:LENGTH-1];
    logic [ROW_ADDR_WIDTH-1:0] row_rdaddr   [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]     row_rddata   [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]     row_data_out [0:LENGTH-1];

    modport slave (
        input  start, row_count, row_rddata,
        output busy, done, row_rd_en, row_rdaddr, row_data_out
    );

    modport master (
        output start, row_count, row_rddata,
        input  busy, done, row_rd_en, row_rdaddr, row_data_out
    );
endinterface

// File: rtl/systolic_ws_feeder.sv
// rtl/systolic_ws_feeder.sv - skewed row feeder for the weight-stationary systolic array west edge
//
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    systolic_ws_feeder_if.slave: start/row_count command, busy/done status,
//          per-lane SRAM read port, skewed row_data_out lanes
//
// Lane k reads row r at t = r + k, so the diagonal skew comes entirely from
// staggered addresses; the only per-lane state is a registered valid that masks
// the SRAM read data one cycle later.
module systolic_ws_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_NUM    = 8,
    parameter int LENGTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_ws_feeder_if.slave  bus
);
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);
    localparam int CNT_WIDTH      = $clog2(ROW_NUM + LENGTH);

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    // One extra bit so lane offsets and window bounds never wrap.
    typedef logic [CNT_WIDTH:0]   ext_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;
    cnt_t   t_q;
    cnt_t   n_q;
    logic   vld_q [0:LENGTH-1];

    logic                      rd_en    [0:LENGTH-1];
    logic [ROW_ADDR_WIDTH-1:0] rd_addr  [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]     data_out [0:LENGTH-1];

    ext_t t_ext;
    ext_t n_ext;
    ext_t last_t;

    assign t_ext = ext_t'(t_q);
    assign n_ext = ext_t'(n_q);
    // Last RUN cycle is the last read; an empty batch still spends one RUN cycle.
    assign last_t = (n_q == '0) ? '0 : (n_ext + ext_t'(LENGTH) - ext_t'(2));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (t_ext == last_t) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ext_t lane;
        ext_t diff;
        for (int k = 0; k < LENGTH; k++) begin
            lane        = ext_t'(k);
            diff        = t_ext - lane;
            rd_en[k]    = 1'b0;
            rd_addr[k]  = '0;
            if ((state == RUN) && (t_ext >= lane) && (t_ext < lane + n_ext)) begin
                rd_en[k]   = 1'b1;
                rd_addr[k] = diff[ROW_ADDR_WIDTH-1:0];
            end
            data_out[k] = vld_q[k] ? bus.row_rddata[k] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            t_q   <= '0;
            n_q   <= '0;
            for (int k = 0; k < LENGTH; k++) begin
                vld_q[k] <= 1'b0;
            end
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.start) begin
                t_q <= '0;
                n_q <= (bus.row_count > cnt_t'(ROW_NUM)) ? cnt_t'(ROW_NUM) : bus.row_count;
            end else if (state == RUN) begin
                t_q <= t_q + cnt_t'(1);
            end
            for (int k = 0; k < LENGTH; k++) begin
                vld_q[k] <= rd_en[k];
            end
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DRAIN);
    assign bus.row_rd_en    = rd_en;
    assign bus.row_rdaddr   = rd_addr;
    assign bus.row_data_out = data_out;
endmodule

// File: tb/tb_systolic_ws_feeder.sv
// tb/tb_systolic_ws_feeder.sv - scoreboard bench for systolic_ws_feeder (LENGTH=3, ROW_NUM=4, DATA_WIDTH=8)
module tb_systolic_ws_feeder;
    localparam int DW = 8;
    localparam int RN = 4;
    localparam int L  = 3;
    localparam int AW = $clog2(RN);
    localparam int CW = $clog2(RN + L);

    typedef struct packed {
        logic            busy;
        logic            done;
        logic [L-1:0]    en;
        logic [L*AW-1:0] addr;
        logic [L*DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    systolic_ws_feeder_if #(.DATA_WIDTH(DW), .ROW_NUM(RN), .LENGTH(L)) bus ();

    systolic_ws_feeder #(.DATA_WIDTH(DW), .ROW_NUM(RN), .LENGTH(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Source SRAM: mem[k][r] = 16k + r, 1-cycle latency; junk when not read so masking is visible.
    always @(posedge clk) begin
        for (int k = 0; k < L; k++) begin
            bus.row_rddata[k] <= bus.row_rd_en[k] ? DW'(16 * k + int'(bus.row_rdaddr[k])) : 8'hEE;
        end
    end

    task automatic compare(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e = '0;
        q.push_back(e);
    endtask

    // Expected per-cycle trace for a batch of n rows, starting at t=0.
    task automatic push_batch(input int n);
        exp_t e;
        int   tend;
        tend = (n == 0) ? 1 : n + L - 1;
        for (int t = 0; t <= tend; t++) begin
            e      = '0;
            e.busy = 1'b1;
            e.done = (t == tend);
            for (int k = 0; k < L; k++) begin
                if (t < tend && t >= k && t < k + n) begin
                    e.en[k]            = 1'b1;
                    e.addr[k*AW +: AW] = AW'(t - k);
                end
                if (t >= k + 1 && t < k + 1 + n) begin
                    e.data[k*DW +: DW] = DW'(16 * k + (t - k - 1));
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic check_now();
        exp_t e;
        exp_t a;
        a = '0;
        a.busy = bus.busy;
        a.done = bus.done;
        for (int k = 0; k < L; k++) begin
            a.en[k]            = bus.row_rd_en[k];
            a.addr[k*AW +: AW] = bus.row_rdaddr[k];
            a.data[k*DW +: DW] = bus.row_data_out[k];
        end
        if (q.size() == 0) begin
            compare("scoreboard_empty", 64'(q.size()), 64'd1);
        end else begin
            e = q.pop_front();
            compare("busy", 64'(a.busy), 64'(e.busy));
            compare("done", 64'(a.done), 64'(e.done));
            compare("row_rd_en", 64'(a.en), 64'(e.en));
            compare("row_rdaddr", 64'(a.addr), 64'(e.addr));
            compare("row_data_out", 64'(a.data), 64'(e.data));
        end
    endtask

    task automatic check_cycle();
        @(negedge clk);
        check_now();
    endtask

    // Issue one start (dropped after acceptance) and check the batch plus the following idle cycle.
    task automatic run_batch(input int rc);
        bus.start     = 1'b1;
        bus.row_count = CW'(rc);
        push_batch((rc > RN) ? RN : rc);
        push_idle();
        check_cycle();
        bus.start = 1'b0;
        while (q.size() > 0) check_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.row_count = '0;

        // Reset state
        @(negedge clk);
        push_idle();
        check_cycle();
        reset = 1'b1;
        push_idle();
        check_cycle();

        // Full batch
        run_batch(4);

        // Reset in the middle of a batch with lanes active
        bus.start     = 1'b1;
        bus.row_count = CW'(4);
        push_batch(4);
        check_cycle();
        bus.start = 1'b0;
        repeat (3) check_cycle();
        q.delete();
        reset = 1'b0;
        #1;
        push_idle();
        check_now();
        push_idle();
        check_cycle();
        reset = 1'b1;
        push_idle();
        check_cycle();

        // Partial batch after reset
        run_batch(2);

        // Empty batch
        run_batch(0);

        // Oversized row_count clamps to ROW_NUM
        run_batch(7);

        // Start held high: accepted only in IDLE, ignored during done
        bus.start     = 1'b1;
        bus.row_count = CW'(4);
        push_batch(4);
        push_idle();
        push_batch(4);
        push_idle();
        push_idle();
        while (q.size() > 2) check_cycle();
        bus.start = 1'b0;
        while (q.size() > 0) check_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
